calc_stream_controller: RTL and testbench
=========================================

Name: calc_stream_controller

Overview:
Parametrised next-generation calculator controller. It streams operand words from a memory region, feeds the external adder one operand pair per cycle, and packs the results into full-width words in an internal packing buffer. Each packed word is written to a destination region. It adds a start/busy/done handshake, add/sub mode, multi-pair read words, inclusive end-address limits and partial-word flush. It sits between the shared memory and the adder, in place of the fixed two-result controller.

Parameters:
ADDR_W, 10, memory address width
DATA_W, 32, operand/result width
MEM_WORD_SIZE, 64, memory word width; must be a multiple of 2*DATA_W
(localparam) PACK = MEM_WORD_SIZE/DATA_W, results per write word (power of two, >=2)
(localparam) PAIRS = PACK/2, operand pairs per read word

Ports:
clk_i  in  1  clock
rst_i  in  1  reset (synchronous, active-high)
start_i  in  1  start request; sampled in S_IDLE only
mode_i  in  1  0=add, 1=sub; latched on start
read_start_addr, read_end_addr  in  ADDR_W  inclusive source range; latched on start
write_start_addr, write_end_addr  in  ADDR_W  inclusive destination range; latched on start
read_n  out  1  active-low memory read enable
r_addr  out  ADDR_W  read address
r_data  in  MEM_WORD_SIZE  read data, valid the cycle after read_n low
write_n  out  1  active-low memory write enable
w_addr  out  ADDR_W  write address
w_data  out  MEM_WORD_SIZE  packed write data
op_a, op_b  out  DATA_W  adder operands
op_sub  out  1  adder subtract select (= latched mode)
sum_i  in  DATA_W  combinational adder result for op_a/op_b this cycle
busy_o  out  1  high from the cycle after an accepted start through S_DONE
done_o  out  1  one-cycle pulse in S_DONE

Behaviour:
- Reset: state S_IDLE; read_n=1, write_n=1, busy_o=0, done_o=0; r_addr, w_addr, op_a, op_b, w_data, op_sub, and all internal registers = 0. Reset wins over every other event, including mid-operation: no further memory access follows.
- States: S_IDLE, S_READ, S_LOAD, S_ADD, S_WRITE, S_DONE.
- S_IDLE:
  - start_i=1 latches all ranges and mode_i, clears the packing buffer and slot counter, then goes to S_READ.
  - If either range has end<start, go to S_DONE instead; no memory access occurs.
- S_READ: read_n=0 at r_addr for exactly 1 cycle -> S_LOAD.
- S_LOAD: capture r_data into the operand register; pair index p=0 -> S_ADD.
- S_ADD: one cycle per pair.
  - op_a = opreg[(2p+1)*DATA_W +: DATA_W]; op_b = opreg[2p*DATA_W +: DATA_W].
  - sum_i is stored into buffer slot k at [k*DATA_W +: DATA_W]; slot 0 is filled first; k increments.
  - After pair PAIRS-1, r_addr increments, then:
    - buffer full (k wraps to 0) or last source word consumed -> S_WRITE;
    - otherwise -> S_READ.
- S_WRITE: write_n=0 for 1 cycle at w_addr with w_data = buffer; unfilled slots are zero. Buffer is then cleared and w_addr increments. Next state:
  - -> S_DONE if w_addr was write_end_addr or the source is exhausted;
  - -> S_READ otherwise.
- S_DONE: done_o=1 for 1 cycle -> S_IDLE. busy_o drops in S_IDLE.
- Outputs outside their states: read_n=1 and write_n=1; op_a/op_b hold their last values.
- Arithmetic: modulo 2^DATA_W; no saturation.
- Addresses: compared with equality to the latched end addresses, so end=2^ADDR_W-1 terminates without wrap.
- Latency per full write word: (2+PAIRS)*(PACK/PAIRS) + 1 cycles.

Optional Feature:
CALC_OVF_FLAG_EN:
- When defined, adds input carry_i (1) and output ovf_o (1).
- ovf_o is sticky-set in any S_ADD cycle where carry_i=1 (add carry-out or sub borrow) and is cleared on accepted start and on reset.
- When undefined, neither port exists and behaviour is otherwise identical.

Decomposition:
- calculator_pkg gains stream_state_t (the six states), ADDR_W/DATA_W/MEM_WORD_SIZE defaults and a MODE_ADD/MODE_SUB constant pair.
- One sub-module, calc_result_packer, holds the PACK-slot buffer, slot counter, full flag, clear and zero-fill behaviour; the controller FSM instantiates it.

Test Plan:
- DATA_W=32/MEM=64; mem[0]={5,3}, mem[1]={10,20}; read 0..1, write 8..8, add -> mem[8]={30,8}. Sequence is exactly READ,LOAD,ADD,READ,LOAD,ADD,WRITE,DONE; done_o pulses once.
- Odd count: read 0..2 (mem[2]={1,1}), write 8..9 -> mem[9]={0,2}; exactly 2 writes.
- Write limit: read 0..5, write 8..8 -> only mem[8] written; only addresses 0,1 read; done_o after 1 write.
- Sub mode with wrap: mem[0]={3,5} -> slot0=0xFFFFFFFE; with CALC_OVF_FLAG_EN, ovf_o=1 until next start.
- MEM=128/DATA_W=32: mem[0]={4,3,2,1} -> op pairs (2,1) then (4,3); read 0..1 gives mem[8] = {s3,s2,7,3}, where s2 and s3 are the sums of mem[1]'s two pairs.
- rst_i asserted during S_ADD -> next cycle S_IDLE with all outputs at reset values; start_i during busy is ignored; end<start gives done_o with no read_n/write_n activity.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared types and defaults for the streaming calculator controller.
// Optional overflow flag is enabled with the CALC_OVF_FLAG_EN macro.
package calculator_pkg;

    localparam int DEF_ADDR_W        = 10;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_MEM_WORD_SIZE = 64;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_ADD,
        S_WRITE,
        S_DONE
    } stream_state_t;

endpackage

// File: rtl/calc_result_packer.sv
// PACK-slot result buffer: fills slot 0 first, flags the write that fills the
// last slot, and zero-fills on clear so partial words flush with empty slots.
module calc_result_packer #(
    parameter int DATA_W = 32,
    parameter int PACK   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [PACK*DATA_W-1:0]   buf_o,
    output logic                     full_o
);

    localparam int K_W = $clog2(PACK);

    logic [K_W-1:0]          slot_q;
    logic [PACK*DATA_W-1:0]  buf_q;

    // PACK is a power of two, so the slot counter wraps to 0 on its own.
    assign full_o = wr_en_i && (slot_q == K_W'(PACK - 1));
    assign buf_o  = buf_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from the same pre-edge snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            buf_q  <= '0;
            slot_q <= '0;
        end else if (wr_en_i) begin
            buf_q[int'(slot_q)*DATA_W +: DATA_W] <= data_i;
            slot_q                               <= slot_q + 1'b1;
        end
    end

endmodule

// File: rtl/calc_stream_controller.sv
// Streams operand pairs from memory through the external adder and writes packed
// results back. Define CALC_OVF_FLAG_EN to add carry_i and the sticky ovf_o flag.
module calc_stream_controller
    import calculator_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int MEM_WORD_SIZE = DEF_MEM_WORD_SIZE
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [ADDR_W-1:0]        read_start_addr,
    input  logic [ADDR_W-1:0]        read_end_addr,
    input  logic [ADDR_W-1:0]        write_start_addr,
    input  logic [ADDR_W-1:0]        write_end_addr,
    output logic                     read_n,
    output logic [ADDR_W-1:0]        r_addr,
    input  logic [MEM_WORD_SIZE-1:0] r_data,
    output logic                     write_n,
    output logic [ADDR_W-1:0]        w_addr,
    output logic [MEM_WORD_SIZE-1:0] w_data,
    output logic [DATA_W-1:0]        op_a,
    output logic [DATA_W-1:0]        op_b,
    output logic                     op_sub,
    input  logic [DATA_W-1:0]        sum_i,
    output logic                     busy_o,
    output logic                     done_o
`ifdef CALC_OVF_FLAG_EN
    ,
    input  logic                     carry_i,
    output logic                     ovf_o
`endif
);

    localparam int PACK  = MEM_WORD_SIZE / DATA_W;
    localparam int PAIRS = PACK / 2;
    localparam int P_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    stream_state_t            state_q, state_d;
    logic                     mode_q;
    logic [ADDR_W-1:0]        rd_end_q, wr_end_q;
    logic [ADDR_W-1:0]        r_addr_q, r_addr_d, w_addr_q, w_addr_d;
    logic [MEM_WORD_SIZE-1:0] opreg_q, opreg_d;
    logic [P_W-1:0]           pair_q, pair_d;
    logic [DATA_W-1:0]        op_a_q, op_b_q, add_a, add_b;
    logic                     src_done_q, src_done_d;
    logic                     accept, range_bad, pair_last, src_last;
    logic                     pk_clear, pk_wr, pk_full;
    logic [MEM_WORD_SIZE-1:0] pk_buf;

    assign accept    = (state_q == S_IDLE) && start_i;
    assign range_bad = (read_end_addr < read_start_addr) || (write_end_addr < write_start_addr);
    assign add_a     = opreg_q[(2*int'(pair_q)+1)*DATA_W +: DATA_W];
    assign add_b     = opreg_q[(2*int'(pair_q))*DATA_W +: DATA_W];
    assign pair_last = (pair_q == P_W'(PAIRS - 1));
    assign src_last  = (r_addr_q == rd_end_q);

    calc_result_packer #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_packer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (pk_clear),
        .wr_en_i (pk_wr),
        .data_i  (sum_i),
        .buf_o   (pk_buf),
        .full_o  (pk_full)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        r_addr_d   = r_addr_q;
        w_addr_d   = w_addr_q;
        opreg_d    = opreg_q;
        pair_d     = pair_q;
        src_done_d = src_done_q;
        pk_clear   = 1'b0;
        pk_wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pk_clear   = 1'b1;
                    r_addr_d   = read_start_addr;
                    w_addr_d   = write_start_addr;
                    src_done_d = 1'b0;
                    state_d    = range_bad ? S_DONE : S_READ;
                end
            end
            S_READ:  state_d = S_LOAD;
            S_LOAD: begin
                opreg_d = r_data;
                pair_d  = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                pk_wr = 1'b1;
                if (pair_last) begin
                    r_addr_d = r_addr_q + 1'b1;
                    if (src_last) src_done_d = 1'b1;
                    state_d = (pk_full || src_last) ? S_WRITE : S_READ;
                end else begin
                    pair_d = pair_q + 1'b1;
                end
            end
            S_WRITE: begin
                pk_clear = 1'b1;
                w_addr_d = w_addr_q + 1'b1;
                state_d  = ((w_addr_q == wr_end_q) || src_done_q) ? S_DONE : S_READ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_ADD;
            rd_end_q   <= '0;
            wr_end_q   <= '0;
            r_addr_q   <= '0;
            w_addr_q   <= '0;
            opreg_q    <= '0;
            pair_q     <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            src_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_addr_q   <= r_addr_d;
            w_addr_q   <= w_addr_d;
            opreg_q    <= opreg_d;
            pair_q     <= pair_d;
            src_done_q <= src_done_d;
            if (accept) begin
                mode_q   <= mode_i;
                rd_end_q <= read_end_addr;
                wr_end_q <= write_end_addr;
            end
            if (state_q == S_ADD) begin
                op_a_q <= add_a;
                op_b_q <= add_b;
            end
        end
    end

    // Operands are live in S_ADD so sum_i is valid the same cycle; held otherwise.
    assign op_a    = (state_q == S_ADD) ? add_a : op_a_q;
    assign op_b    = (state_q == S_ADD) ? add_b : op_b_q;
    assign op_sub  = (mode_q == MODE_SUB);
    assign read_n  = (state_q != S_READ);
    assign write_n = (state_q != S_WRITE);
    assign r_addr  = r_addr_q;
    assign w_addr  = w_addr_q;
    assign w_data  = pk_buf;
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);

`ifdef CALC_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || accept) begin
            ovf_q <= 1'b0;
        end else if ((state_q == S_ADD) && carry_i) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_calc_stream_controller.sv
// Directed bench: 64-bit and 128-bit word instances, behavioural memories and adder.
module tb_calc_stream_controller;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start64, start128, mode;
    logic [AW-1:0] ra0, ra1, wa0, wa1;

    logic          read_n64, write_n64, op_sub64, busy64, done64;
    logic [AW-1:0] r_addr64, w_addr64;
    logic [63:0]   r_data64, w_data64;
    logic [DW-1:0] op_a64, op_b64, sum64;

    logic          read_n128, write_n128, op_sub128, busy128, done128;
    logic [AW-1:0] r_addr128, w_addr128;
    logic [127:0]  r_data128, w_data128;
    logic [DW-1:0] op_a128, op_b128, sum128;

    assign sum64  = op_sub64  ? op_a64  - op_b64  : op_a64  + op_b64;
    assign sum128 = op_sub128 ? op_a128 - op_b128 : op_a128 + op_b128;

`ifdef CALC_OVF_FLAG_EN
    logic carry64, ovf64, carry128, ovf128;

    function automatic logic carry_of(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return sub ? (a < b) : s[DW];
    endfunction

    assign carry64  = carry_of(op_a64, op_b64, op_sub64);
    assign carry128 = carry_of(op_a128, op_b128, op_sub128);
`endif

    calc_stream_controller #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORD_SIZE(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .start_i(start64), .mode_i(mode),
        .read_start_addr(ra0), .read_end_addr(ra1),
        .write_start_addr(wa0), .write_end_addr(wa1),
        .read_n(read_n64), .r_addr(r_addr64), .r_data(r_data64),
        .write_n(write_n64), .w_addr(w_addr64), .w_data(w_data64),
        .op_a(op_a64), .op_b(op_b64), .op_sub(op_sub64), .sum_i(sum64),
        .busy_o(busy64), .done_o(done64)
`ifdef CALC_OVF_FLAG_EN
        , .carry_i(carry64), .ovf_o(ovf64)
`endif
    );

    calc_stream_controller #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORD_SIZE(128)) dut128 (
        .clk_i(clk), .rst_i(rst), .start_i(start128), .mode_i(mode),
        .read_start_addr(ra0), .read_end_addr(ra1),
        .write_start_addr(wa0), .write_end_addr(wa1),
        .read_n(read_n128), .r_addr(r_addr128), .r_data(r_data128),
        .write_n(write_n128), .w_addr(w_addr128), .w_data(w_data128),
        .op_a(op_a128), .op_b(op_b128), .op_sub(op_sub128), .sum_i(sum128),
        .busy_o(busy128), .done_o(done128)
`ifdef CALC_OVF_FLAG_EN
        , .carry_i(carry128), .ovf_o(ovf128)
`endif
    );

    logic [63:0]  mem64  [0:1023];
    logic [127:0] mem128 [0:1023];
    int           rd_cnt64, wr_cnt64, len64, rd_cnt128, wr_cnt128, len128;
    logic [15:0]  rd_mask64;
    logic [63:0]  trace64, trace128;
    int           errors = 0;
    int           checks = 0;

    always @(posedge clk) begin
        if (!read_n64) begin
            r_data64 <= mem64[r_addr64];
            rd_cnt64 = rd_cnt64 + 1;
            rd_mask64[r_addr64[3:0]] = 1'b1;
        end
        if (!write_n64) begin
            mem64[w_addr64] = w_data64;
            wr_cnt64 = wr_cnt64 + 1;
        end
        if (!read_n128) begin
            r_data128 <= mem128[r_addr128];
            rd_cnt128 = rd_cnt128 + 1;
        end
        if (!write_n128) begin
            mem128[w_addr128] = w_data128;
            wr_cnt128 = wr_cnt128 + 1;
        end
    end

    // One hex digit per busy cycle: 1=read, 2=write, 3=done, 0=other.
    always @(negedge clk) begin
        if (busy64) begin
            trace64 = {trace64[59:0], (!read_n64 ? 4'h1 : !write_n64 ? 4'h2 : done64 ? 4'h3 : 4'h0)};
            len64 = len64 + 1;
        end
        if (busy128) begin
            trace128 = {trace128[59:0], (!read_n128 ? 4'h1 : !write_n128 ? 4'h2 : done128 ? 4'h3 : 4'h0)};
            len128 = len128 + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        trace64 = '0; len64 = 0; rd_cnt64 = 0; wr_cnt64 = 0; rd_mask64 = '0;
        trace128 = '0; len128 = 0; rd_cnt128 = 0; wr_cnt128 = 0;
    endtask

    task automatic wait_done(input bit wide);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wide ? done128 : done64) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", seen, 1'b1);
        @(negedge clk);
    endtask

    task automatic run(input bit wide, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [AW-1:0] w0, input logic [AW-1:0] w1, input logic m);
        @(negedge clk);
        ra0 = r0; ra1 = r1; wa0 = w0; wa1 = w1; mode = m;
        clear_logs();
        if (wide) start128 = 1'b1; else start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0; start128 = 1'b0;
        wait_done(wide);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {read_n64, write_n64, busy64, done64, op_sub64}, 5'b11000);
        check({tag, "_addr"}, {r_addr64, w_addr64}, '0);
        check({tag, "_data"}, {w_data64, op_a64, op_b64}, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_snap;
        rst = 1'b1; start64 = 1'b0; start128 = 1'b0; mode = 1'b0;
        ra0 = '0; ra1 = '0; wa0 = '0; wa1 = '0;
        for (int i = 0; i < 1024; i++) begin
            mem64[i] = '0;
            mem128[i] = '0;
        end
        clear_logs();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic add: two read words fill one write word.
        mem64[0] = {32'd5, 32'd3};
        mem64[1] = {32'd10, 32'd20};
        run(1'b0, 0, 1, 8, 8, 1'b0);
        check("add_mem8", mem64[8], {32'd30, 32'd8});
        check("add_seq", trace64, 64'h10010023);
        check("add_len", len64, 8);
        check("add_writes", wr_cnt64, 1);
        check("add_op_hold", {op_a64, op_b64}, {32'd10, 32'd20});

        // Odd source count flushes a partial word with zero fill.
        mem64[2] = {32'd1, 32'd1};
        mem64[8] = '0;
        run(1'b0, 0, 2, 8, 9, 1'b0);
        check("odd_mem8", mem64[8], {32'd30, 32'd8});
        check("odd_mem9", mem64[9], {32'd0, 32'd2});
        check("odd_writes", wr_cnt64, 2);
        check("odd_seq", trace64, 64'h100100210023);

        // Write limit stops the stream after one destination word.
        mem64[8] = '0; mem64[9] = '0;
        mem64[3] = {32'd7, 32'd7}; mem64[4] = {32'd9, 32'd9}; mem64[5] = {32'd1, 32'd2};
        run(1'b0, 0, 5, 8, 8, 1'b0);
        check("lim_mem8", mem64[8], {32'd30, 32'd8});
        check("lim_mem9", mem64[9], 64'd0);
        check("lim_writes", wr_cnt64, 1);
        check("lim_rd_mask", rd_mask64, 16'h0003);

        // Subtract with wrap-around.
        mem64[0] = {32'd3, 32'd5};
        run(1'b0, 0, 0, 8, 8, 1'b1);
        check("sub_mem8", mem64[8], {32'd0, 32'hFFFF_FFFE});
        check("sub_seq", trace64, 64'h10023);
`ifdef CALC_OVF_FLAG_EN
        check("sub_ovf", ovf64, 1'b1);
        repeat (4) @(negedge clk);
        check("sub_ovf_sticky", ovf64, 1'b1);
`endif

        // Start during busy is ignored, as are range/mode changes.
        mem64[0] = {32'd5, 32'd3};
        mem64[8] = '0;
        @(negedge clk);
        ra0 = 0; ra1 = 1; wa0 = 8; wa1 = 8; mode = 1'b0;
        clear_logs();
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        @(negedge clk);
        ra1 = 0; wa0 = 20; mode = 1'b1; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        wait_done(1'b0);
        check("busy_mem8", mem64[8], {32'd30, 32'd8});
        check("busy_seq", trace64, 64'h10010023);
        check("busy_mem20", mem64[20], 64'd0);
`ifdef CALC_OVF_FLAG_EN
        check("ovf_cleared", ovf64, 1'b0);
`endif

        // Inverted ranges: done with no memory access.
        run(1'b0, 3, 2, 8, 8, 1'b0);
        check("bad_rd_seq", trace64, 64'h3);
        check("bad_rd_access", {rd_cnt64, wr_cnt64}, 64'd0);
        run(1'b0, 0, 1, 9, 8, 1'b0);
        check("bad_wr_seq", trace64, 64'h3);
        check("bad_wr_access", {rd_cnt64, wr_cnt64}, 64'd0);

        // Reset in S_ADD aborts the operation.
        @(negedge clk);
        ra0 = 0; ra1 = 1; wa0 = 8; wa1 = 8; mode = 1'b1;
        clear_logs();
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_add", {read_n64, write_n64, busy64, op_sub64, op_a64}, {4'b1111, 32'd5});
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        rd_snap = rd_cnt64;
        repeat (6) @(negedge clk);
        check("midrst_no_access", {rd_cnt64, wr_cnt64, busy64}, {rd_snap, 32'd0, 1'b0});

        // Wide words: two pairs per read, four results per write.
        mem128[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        mem128[1] = {32'd8, 32'd7, 32'd6, 32'd5};
        run(1'b1, 0, 1, 8, 8, 1'b0);
        check("wide_mem8", mem128[8], {32'd15, 32'd11, 32'd7, 32'd3});
        check("wide_seq", trace128, 64'h1000100023);
        check("wide_len", len128, 10);
        check("wide_op_hold", {op_a128, op_b128}, {32'd8, 32'd7});
        check("wide_access", {rd_cnt128, wr_cnt128}, {32'd2, 32'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
